wmul_seq: RTL and testbench

Multi-cycle sequencer for the WideWord unsigned subfield multiply (`wmulou` odd subfields, `wmuleu` even subfields). It replaces the single-cycle combinational multiply path in the ALU with an iterative shift-add engine. All lanes advance in parallel, one multiplier bit per cycle. It sits beside the ALU in the execute stage: the pipeline issues a start pulse, then stalls on `busy` and captures `result` on `done`.

---
 rtl/wmul_seq_pkg.sv | 34 +++
 rtl/wmul_seq_mul_lane_step.sv | 15 +
 rtl/wmul_seq.sv | 121 ++++++++++++
 tb/tb_wmul_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/wmul_seq_pkg.sv
// Shared encodings and lane payload type for the WideWord subfield multiply sequencer.
package wmul_seq_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned LANES  = 8;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned MPL_W  = 16;
  localparam int unsigned CNT_W  = 5;

  localparam logic [4:0] ALU_WMULOU = 5'b01100;
  localparam logic [4:0] ALU_WMULEU = 5'b01101;

  localparam logic [1:0] WW_W8  = 2'b00;
  localparam logic [1:0] WW_W16 = 2'b01;
  localparam logic [1:0] WW_W32 = 2'b10;
  localparam logic [1:0] WW_W64 = 2'b11;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] mcand;
    logic [MPL_W-1:0] mplier;
  } lane_t;

  function automatic logic op_legal(input logic [4:0] op, input logic [1:0] ww);
    return ((op == ALU_WMULOU) || (op == ALU_WMULEU)) && ((ww == WW_W8) || (ww == WW_W16));
  endfunction

endpackage

// File: rtl/wmul_seq_mul_lane_step.sv
// One shift-add multiply step for a single 32-bit lane.
module mul_lane_step
  import wmul_seq_pkg::*;
(
  input  lane_t cur,
  output lane_t nxt_c
);

  always_comb begin : step
    nxt_c.acc    = cur.mplier[0] ? (cur.acc + cur.mcand) : cur.acc;
    nxt_c.mcand  = {cur.mcand[ACC_W-2:0], 1'b0};
    nxt_c.mplier = {1'b0, cur.mplier[MPL_W-1:1]};
  end

endmodule

// File: rtl/wmul_seq.sv
// Iterative unsigned odd/even subfield multiply; all lanes step one multiplier bit per cycle.
// Vectors are [127:0]: big-endian bit label i of the datapath is index 127-i here.
module wmul_seq
  import wmul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] reg_A,
  input  logic [DATA_W-1:0] reg_B,
  input  logic [1:0]        ctrl_ww,
  input  logic [4:0]        alu_op,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  ms_state_e         state_q, state_d;
  logic              busy_d, done_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              ww16_q;
  lane_t             lane_q  [LANES];
  lane_t             lane_c  [LANES];
  lane_t             lane_ld [LANES];
  logic [DATA_W-1:0] result_c;
  logic              accept_c, legal_c, odd_c, last_c;

  assign accept_c = (state_q == MS_IDLE) && start;
  assign legal_c  = op_legal(alu_op, ctrl_ww);
  assign odd_c    = (alu_op == ALU_WMULOU);
  assign last_c   = (state_q == MS_RUN) && (cnt_q == CNT_W'(1));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mul_lane_step u_step (
      .cur   (lane_q[g]),
      .nxt_c (lane_c[g])
    );
  end

  // Operand extraction: pick odd or even subfields into the low end of each lane
  always_comb begin : load_mux
    for (int k = 0; k < LANES; k++) lane_ld[k] = '0;
    if (ctrl_ww == WW_W16) begin
      for (int k = 0; k < 4; k++) begin
        if (odd_c) begin
          lane_ld[k].mplier = reg_A[111-32*k -: 16];
          lane_ld[k].mcand  = ACC_W'(reg_B[111-32*k -: 16]);
        end else begin
          lane_ld[k].mplier = reg_A[127-32*k -: 16];
          lane_ld[k].mcand  = ACC_W'(reg_B[127-32*k -: 16]);
        end
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (odd_c) begin
          lane_ld[k].mplier = MPL_W'(reg_A[119-16*k -: 8]);
          lane_ld[k].mcand  = ACC_W'(reg_B[119-16*k -: 8]);
        end else begin
          lane_ld[k].mplier = MPL_W'(reg_A[127-16*k -: 8]);
          lane_ld[k].mcand  = ACC_W'(reg_B[127-16*k -: 8]);
        end
      end
    end
  end

  // Pack the post-step accumulators into result lane order
  always_comb begin : pack
    result_c = '0;
    if (ww16_q) begin
      for (int k = 0; k < 4; k++) result_c[127-32*k -: 32] = lane_c[k].acc;
    end else begin
      for (int k = 0; k < LANES; k++) result_c[127-16*k -: 16] = lane_c[k].acc[15:0];
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state_q <= MS_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      MS_IDLE: if (start) state_d = legal_c ? MS_RUN : MS_DONE;
      MS_RUN:  if (cnt_q == CNT_W'(1)) state_d = MS_DONE;
      MS_DONE: state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  always_comb begin : outputs
    busy_d = (state_d != MS_IDLE);
    done_d = (state_d == MS_DONE);
  end

  always_ff @(posedge clk) begin : datapath
    if (reset) begin
      cnt_q  <= '0;
      ww16_q <= 1'b0;
      result <= '0;
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
    end else if (accept_c) begin
      cnt_q  <= (ctrl_ww == WW_W16) ? CNT_W'(16) : CNT_W'(8);
      ww16_q <= (ctrl_ww == WW_W16);
      for (int k = 0; k < LANES; k++) lane_q[k] <= lane_ld[k];
      if (!legal_c) result <= '0;
    end else if (state_q == MS_RUN) begin
      cnt_q <= cnt_q - CNT_W'(1);
      for (int k = 0; k < LANES; k++) lane_q[k] <= lane_c[k];
      if (last_c) result <= result_c;
    end
  end

endmodule

// File: tb/tb_wmul_seq.sv
// Self-checking bench for wmul_seq: directed cases plus randomized ops against an arithmetic model.
module tb_wmul_seq;
  import wmul_seq_pkg::*;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [127:0] reg_A, reg_B, result;
  logic [1:0]   ctrl_ww;
  logic [4:0]   alu_op;
  logic         busy, done;

  int           checks = 0;
  int           errors = 0;
  logic [127:0] last_exp = '0;

  always #5 clk = ~clk;

  wmul_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .reg_A   (reg_A),
    .reg_B   (reg_B),
    .ctrl_ww (ctrl_ww),
    .alu_op  (alu_op),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Field number idx of width w, counted from the MSB end
  function automatic longint unsigned fld(input logic [127:0] v, input int w, input int idx);
    logic [127:0] t;
    t = v >> (128 - w * (idx + 1));
    return 64'(t) & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic is_legal(input logic [1:0] ww, input logic [4:0] op);
    return (op == ALU_WMULOU || op == ALU_WMULEU) && (ww == WW_W8 || ww == WW_W16);
  endfunction

  function automatic logic [127:0] model(input logic [127:0] a, input logic [127:0] b,
                                         input logic [1:0] ww, input logic [4:0] op);
    logic [127:0] r;
    int n, sub;
    longint unsigned p;
    if (!is_legal(ww, op)) return '0;
    n = (ww == WW_W8) ? 8 : 16;
    r = '0;
    for (int k = 0; k < 64 / n; k++) begin
      sub = 2 * k + ((op == ALU_WMULOU) ? 1 : 0);
      p   = fld(a, n, sub) * fld(b, n, sub);
      r   = r | (128'(p) << (128 - 2 * n * (k + 1)));
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, follow it to done, check latency, busy, held result and final product
  task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic [1:0] ww,
                        input logic [4:0] op, input string tag);
    logic [127:0] exp;
    int cyc, exp_cyc;
    logic busy_ok, hold_ok;
    exp     = model(a, b, ww, op);
    exp_cyc = !is_legal(ww, op) ? 1 : ((ww == WW_W8) ? 9 : 17);
    reg_A = a; reg_B = b; ctrl_ww = ww; alu_op = op; start = 1'b1;
    step();
    start = 1'b0;
    reg_A = rand128(); reg_B = rand128();
    ctrl_ww = 2'($urandom()); alu_op = 5'($urandom());
    cyc = 1; busy_ok = 1'b1; hold_ok = 1'b1;
    while (done !== 1'b1 && cyc < 40) begin
      busy_ok &= (busy === 1'b1);
      hold_ok &= (result === last_exp);
      step();
      cyc++;
    end
    chk({tag, "_done_cycle"}, 128'(cyc), 128'(exp_cyc));
    chk({tag, "_busy_run"}, 128'(busy_ok), 128'(1));
    chk({tag, "_result_hold"}, 128'(hold_ok), 128'(1));
    chk({tag, "_busy_at_done"}, 128'(busy), 128'(1));
    chk({tag, "_result"}, result, exp);
    step();
    chk({tag, "_idle_after"}, 128'({busy, done}), 128'(0));
    last_exp = exp;
  endtask

  initial begin
    logic [127:0] a, b, exp1, got;
    logic [1:0]   ww;
    logic [4:0]   op;
    int           nd, dcyc;

    reset = 1'b1; start = 1'b0; reg_A = '0; reg_B = '0; ctrl_ww = WW_W8; alu_op = ALU_WMULOU;
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_result", result, 128'(0));

    a = {8{16'h00FF}};
    run_op(a, a, WW_W8, ALU_WMULOU, "w8_odd_ff");
    chk("w8_odd_ff_const", result, {8{16'hFE01}});

    run_op({16'hFFFF, 112'd0}, {16'h0002, 112'd0}, WW_W16, ALU_WMULEU, "w16_even");
    chk("w16_even_const", result, {32'h0001FFFE, 96'd0});

    run_op(rand128(), rand128(), WW_W8, 5'd0, "illegal_op");
    run_op(rand128(), rand128(), WW_W32, ALU_WMULOU, "illegal_w32");
    run_op('0, rand128(), WW_W16, ALU_WMULEU, "zero_operand");

    for (int i = 0; i < 10; i++) begin
      ww = ($urandom_range(0, 1) == 0) ? WW_W8 : WW_W16;
      op = ($urandom_range(0, 1) == 0) ? ALU_WMULOU : ALU_WMULEU;
      run_op(rand128(), rand128(), ww, op, $sformatf("rand%0d", i));
    end

    // Second start during RUN must be ignored
    a = rand128(); b = rand128();
    exp1 = model(a, b, WW_W8, ALU_WMULOU);
    reg_A = a; reg_B = b; ctrl_ww = WW_W8; alu_op = ALU_WMULOU; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    reg_A = rand128(); reg_B = rand128(); alu_op = ALU_WMULEU; start = 1'b1;
    step();
    start = 1'b0;
    nd = 0; dcyc = 0; got = '0;
    for (int c = 5; c < 30; c++) begin
      if (done === 1'b1) begin
        nd++;
        if (dcyc == 0) begin
          dcyc = c;
          got  = result;
        end
      end
      step();
    end
    chk("busy_start_ndone", 128'(nd), 128'(1));
    chk("busy_start_cycle", 128'(dcyc), 128'(9));
    chk("busy_start_result", got, exp1);
    chk("busy_start_held", result, exp1);

    // Reset together with start: reset wins
    reg_A = rand128(); reg_B = rand128(); ctrl_ww = WW_W8; alu_op = ALU_WMULEU;
    start = 1'b1; reset = 1'b1;
    step();
    start = 1'b0; reset = 1'b0;
    chk("rst_start_state", 128'({busy, done}), 128'(0));
    chk("rst_start_result", result, 128'(0));
    nd = 0;
    repeat (20) begin
      if (done === 1'b1) nd++;
      step();
    end
    chk("rst_start_no_done", 128'(nd), 128'(0));
    last_exp = '0;

    // Reset mid-run of a w16 op
    run_op(rand128() | 128'd1, rand128() | 128'd1, WW_W8, ALU_WMULEU, "pre_reset");
    reg_A = rand128(); reg_B = rand128(); ctrl_ww = WW_W16; alu_op = ALU_WMULOU; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrun_rst_state", 128'({busy, done}), 128'(0));
    chk("midrun_rst_result", result, 128'(0));
    nd = 0;
    repeat (25) begin
      if (done === 1'b1) nd++;
      step();
    end
    chk("midrun_rst_no_done", 128'(nd), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
